craft_byte_link: RTL and testbench

Byte-serial front end for the CRAFT encryption core. It collects plaintext, tweak and key from a byte stream with a valid/ready handshake, starts one encryption and waits for completion. It then returns the 64-bit ciphertext as a byte stream. It sits directly upstream and downstream of `craft_encrypt`, between a host link (UART/DMA bridge) and the core.

---
 rtl/craft_byte_link_pkg.sv | 23 ++
 rtl/craft_byte_link_if.sv | 19 +
 rtl/craft_byte_link.sv | 116 +++++++++++
 tb/tb_craft_byte_link.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/craft_byte_link_pkg.sv
// rtl/craft_byte_link_pkg.sv - shared CRAFT link types, field widths and byte counts
package craft_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    localparam int CRAFT_IN_BYTES  = 32;
    localparam int CRAFT_OUT_BYTES = 8;

    localparam int PT_W    = 64;
    localparam int TWEAK_W = 64;
    localparam int KEY_W   = 128;
    localparam int CT_W    = 64;
    localparam int ASM_W   = PT_W + TWEAK_W + KEY_W;

    localparam int IN_CNT_W  = $clog2(CRAFT_IN_BYTES);
    localparam int OUT_CNT_W = $clog2(CRAFT_OUT_BYTES);

endpackage

// File: rtl/craft_byte_link_if.sv
// rtl/craft_byte_link_if.sv - inbound and outbound byte streams of the CRAFT link
interface craft_byte_link_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/craft_byte_link.sv
// rtl/craft_byte_link.sv - byte-serial loader/unloader wrapped around one CRAFT encryption
module craft_byte_link
    import craft_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    craft_byte_link_if.slave    link,
    output logic [PT_W-1:0]     enc_plaintext,
    output logic [TWEAK_W-1:0]  enc_tweak,
    output logic [KEY_W-1:0]    enc_key,
    output logic                enc_start,
    input  logic                enc_done,
    input  logic [CT_W-1:0]     enc_ciphertext,
    output logic                busy,
    output logic                err_timeout
);

    localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(CRAFT_IN_BYTES - 1);
    localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(CRAFT_OUT_BYTES - 1);
    localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [ASM_W-1:0]      asm_q, asm_d;
    logic [CT_W-1:0]       shf_q, shf_d;
    logic [IN_CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [OUT_CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]      tmo_q, tmo_d, tmo_inc;
    logic                  err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            asm_q     <= '0;
            shf_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            asm_q     <= asm_d;
            shf_q     <= shf_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        shf_d     = shf_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        tmo_inc   = tmo_q + CNT_W'(1);

        case (state_q)
            ST_LOAD: begin
                // Bytes arrive MSB-first, so shifting left leaves byte 0 at the top.
                if (link.in_valid) begin
                    asm_d    = {asm_q[ASM_W-9:0], link.in_data};
                    in_cnt_d = in_cnt_q + IN_CNT_W'(1);
                    if (in_cnt_q == IN_LAST) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                err_d   = 1'b0;
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (enc_done) begin
                    shf_d   = enc_ciphertext;
                    state_d = ST_SEND;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_SEND: begin
                if (link.out_ready) begin
                    shf_d     = {shf_q[CT_W-9:0], 8'h00};
                    out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
                    if (out_cnt_q == OUT_LAST) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Handshake strobes are pure state decodes so no input ever reaches an output.
    assign link.in_ready  = (state_q == ST_LOAD);
    assign link.out_valid = (state_q == ST_SEND);
    assign link.out_data  = shf_q[CT_W-1 -: 8];
    assign enc_start      = (state_q == ST_START);
    assign busy           = (state_q != ST_LOAD);
    assign err_timeout    = err_q;

    assign enc_plaintext  = asm_q[ASM_W-1 -: PT_W];
    assign enc_tweak      = asm_q[KEY_W +: TWEAK_W];
    assign enc_key        = asm_q[KEY_W-1:0];

endmodule

// File: tb/tb_craft_byte_link.sv
// tb/tb_craft_byte_link.sv - directed self-checking bench for craft_byte_link
module tb_craft_byte_link;

    localparam logic [63:0]  PT_A  = 64'h5734F006D8D88A3E;
    localparam logic [63:0]  TW_A  = 64'h54CD94FFD0670A58;
    localparam logic [127:0] KEY_A = 128'h27A6781A43F364BC916708D5FBB5AEFE;
    localparam logic [63:0]  CT_A  = 64'h0123456789ABCDEF;
    localparam logic [63:0]  PT_B  = 64'hFEDCBA9876543210;
    localparam logic [63:0]  TW_B  = 64'h0F1E2D3C4B5A6978;
    localparam logic [127:0] KEY_B = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [63:0]  CT_B  = 64'hA1B2C3D4E5F60718;
    localparam logic [63:0]  CT_C  = 64'h5A5A0FF0C3C33CC3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    craft_byte_link_if lk ();
    craft_byte_link_if lk2 ();

    logic [63:0]  pt, tw, ct_in, pt2, tw2, ct2_in;
    logic [127:0] key, key2;
    logic         start, done, busy, err;
    logic         start2, done2, busy2, err2;

    craft_byte_link dut (
        .clk(clk), .rst_n(rst_n), .link(lk.slave),
        .enc_plaintext(pt), .enc_tweak(tw), .enc_key(key),
        .enc_start(start), .enc_done(done), .enc_ciphertext(ct_in),
        .busy(busy), .err_timeout(err)
    );

    craft_byte_link #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut_to (
        .clk(clk), .rst_n(rst_n), .link(lk2.slave),
        .enc_plaintext(pt2), .enc_tweak(tw2), .enc_key(key2),
        .enc_start(start2), .enc_done(done2), .enc_ciphertext(ct2_in),
        .busy(busy2), .err_timeout(err2)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int cyc_no = 0;
    int core_lat = 40;
    logic [63:0]  core_ct;
    logic [255:0] blk_a, blk_b;

    initial forever begin
        @(posedge clk);
        cyc_no++;
    end

    initial forever begin
        @(negedge clk);
        if (start === 1'b1) start_cnt++;
    end

    // Core model: one-cycle done pulse core_lat cycles after the start cycle.
    initial begin
        done = 1'b0;
        ct_in = '0;
        forever begin
            @(negedge clk);
            if (start === 1'b1) begin
                repeat (core_lat) @(negedge clk);
                ct_in = core_ct;
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        lk.in_data = b;
        lk.in_valid = 1'b1;
        while (lk.in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL push_timeout: in_ready=%b required 1", lk.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic load_block(input logic [255:0] blk, input bit gaps, input int first, input int last);
        for (int i = first; i < last; i++) begin
            push_byte(blk[255-8*i -: 8]);
            if (gaps && (i % 3 == 1) && i != last - 1) begin
                lk.in_valid = 1'b0;
                repeat ((i % 4) + 1) @(negedge clk);
            end
        end
    endtask

    task automatic pop_block(input logic [63:0] ct, input bit bp, input int nbytes);
        int idx = 0;
        int k = 0;
        int guard = 0;
        logic rdy;
        logic hs;
        logic [3:0] pat = 4'b1001;
        while (idx < nbytes && guard < 500) begin
            hs = 1'b0;
            if (lk.out_valid === 1'b1) begin
                rdy = bp ? pat[k % 4] : 1'b1;
                k++;
                n_cmp++;
                if ({lk.out_data, lk.in_ready} !== {ct[63-8*idx -: 8], 1'b0}) begin
                    n_fail++;
                    $display("FAIL out_byte%0d: data/in_ready=%h/%b required %h/0",
                             idx, lk.out_data, lk.in_ready, ct[63-8*idx -: 8]);
                end
                lk.out_ready = rdy;
                hs = rdy;
            end else begin
                lk.out_ready = 1'b0;
            end
            @(negedge clk);
            if (hs) idx++;
            guard++;
        end
        lk.out_ready = 1'b0;
        if (guard >= 500) begin
            n_cmp++; n_fail++;
            $display("FAIL pop_timeout: got %0d bytes required %0d", idx, nbytes);
        end
        if (nbytes == 8) begin
            n_cmp++;
            if ({lk.out_valid, lk.in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL send_end: out_valid/in_ready=%b%b required 01", lk.out_valid, lk.in_ready);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lk.in_ready, lk.out_valid, lk.out_data, start, busy, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/vld/data/start/busy/err=%b/%b/%h/%b/%b/%b required 1/0/00/0/0/0",
                     lk.in_ready, lk.out_valid, lk.out_data, start, busy, err);
        end
        n_cmp++;
        if ({pt, tw, key} !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_operands: %h required 0", {pt, tw, key});
        end
        n_cmp++;
        if ({lk2.in_ready, lk2.out_valid, start2, busy2, err2} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl_to: %b required 10000", {lk2.in_ready, lk2.out_valid, start2, busy2, err2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        int s0;
        int n = 0;
        s0 = start_cnt;
        core_ct = CT_A;
        load_block(blk_a, 1'b0, 0, 32);
        lk.in_valid = 1'b0;
        n_cmp++;
        if ({start, lk.in_ready, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL start_cycle: start/in_ready/busy=%b%b%b required 101", start, lk.in_ready, busy);
        end
        n_cmp++;
        if ({pt, tw, key} !== blk_a) begin
            n_fail++;
            $display("FAIL nominal_operands: %h required %h", {pt, tw, key}, blk_a);
        end
        while (lk.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 41) begin
            n_fail++;
            $display("FAIL done_to_valid: %0d cycles required 41", n);
        end
        pop_block(CT_A, 1'b0, 8);
        n_cmp++;
        if (start_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL start_pulses: %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure;
        core_ct = CT_A;
        load_block(blk_a, 1'b0, 0, 32);
        lk.in_valid = 1'b0;
        pop_block(CT_A, 1'b1, 8);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (lk.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_extra_byte: out_valid=%b required 0", lk.out_valid);
        end
    endtask

    task automatic test_gaps;
        core_ct = CT_C;
        load_block(blk_a, 1'b1, 0, 32);
        lk.in_data = blk_a[255:248];
        lk.in_valid = 1'b1;
        n_cmp++;
        if ({pt, tw, key} !== blk_a) begin
            n_fail++;
            $display("FAIL gaps_operands: %h required %h", {pt, tw, key}, blk_a);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({lk.in_ready, pt, tw, key} !== {1'b0, blk_a}) begin
            n_fail++;
            $display("FAIL holdoff_wait: in_ready=%b operands=%h required 0/%h", lk.in_ready, {pt, tw, key}, blk_a);
        end
        pop_block(CT_C, 1'b0, 8);
        load_block(blk_a, 1'b0, 0, 32);
        lk.in_valid = 1'b0;
        n_cmp++;
        if ({start, pt, tw, key} !== {1'b1, blk_a}) begin
            n_fail++;
            $display("FAIL holdoff_reload: start=%b operands=%h required 1/%h", start, {pt, tw, key}, blk_a);
        end
        pop_block(CT_C, 1'b0, 8);
    endtask

    task automatic test_reset_mid;
        load_block(blk_a, 1'b0, 0, 20);
        lk.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lk.in_ready, busy, pt, tw, key} !== {1'b1, 1'b0, 256'd0}) begin
            n_fail++;
            $display("FAIL rst_load: in_ready/busy=%b/%b operands=%h required 1/0/0", lk.in_ready, busy, {pt, tw, key});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        core_ct = CT_B;
        load_block(blk_b, 1'b0, 0, 32);
        lk.in_valid = 1'b0;
        pop_block(CT_B, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lk.in_ready, lk.out_valid, lk.out_data, start, busy, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_send: rdy/vld/data/start/busy/err=%b/%b/%h/%b/%b/%b required 1/0/00/0/0/0",
                     lk.in_ready, lk.out_valid, lk.out_data, start, busy, err);
        end
        n_cmp++;
        if ({pt, tw, key} !== 256'd0) begin
            n_fail++;
            $display("FAIL rst_send_operands: %h required 0", {pt, tw, key});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        core_ct = CT_C;
        load_block(blk_a, 1'b0, 0, 32);
        lk.in_valid = 1'b0;
        pop_block(CT_C, 1'b0, 8);
    endtask

    task automatic test_back_to_back;
        int c0;
        core_ct = CT_A;
        load_block(blk_a, 1'b0, 0, 32);
        lk.in_data = blk_b[255:248];
        lk.in_valid = 1'b1;
        pop_block(CT_A, 1'b0, 8);
        c0 = cyc_no;
        core_ct = CT_B;
        load_block(blk_b, 1'b0, 0, 32);
        lk.in_valid = 1'b0;
        n_cmp++;
        if ({start, 32'(cyc_no - c0 + 1)} !== {1'b1, 32'd33}) begin
            n_fail++;
            $display("FAIL b2b_start: start=%b at cycle %0d required 1 at 33", start, cyc_no - c0 + 1);
        end
        n_cmp++;
        if ({pt, tw, key} !== blk_b) begin
            n_fail++;
            $display("FAIL b2b_operands: %h required %h", {pt, tw, key}, blk_b);
        end
        pop_block(CT_B, 1'b0, 8);
    endtask

    task automatic test_timeout;
        logic saw_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            lk2.in_data = blk_a[255-8*i -: 8];
            lk2.in_valid = 1'b1;
            @(negedge clk);
        end
        lk2.in_valid = 1'b0;
        n_cmp++;
        if ({start2, pt2, tw2, key2} !== {1'b1, blk_a}) begin
            n_fail++;
            $display("FAIL to_start: start=%b operands=%h required 1/%h", start2, {pt2, tw2, key2}, blk_a);
        end
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (lk2.out_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_cmp++;
        if ({err2, busy2} !== 2'b01) begin
            n_fail++;
            $display("FAIL to_before: err/busy=%b%b required 01", err2, busy2);
        end
        @(negedge clk);
        if (lk2.out_valid !== 1'b0) saw_valid = 1'b1;
        n_cmp++;
        if ({err2, lk2.in_ready, saw_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL to_fire: err/in_ready/saw_valid=%b%b%b required 110", err2, lk2.in_ready, saw_valid);
        end
        for (int i = 0; i < 32; i++) begin
            lk2.in_data = blk_b[255-8*i -: 8];
            lk2.in_valid = 1'b1;
            @(negedge clk);
        end
        lk2.in_valid = 1'b0;
        n_cmp++;
        if ({start2, err2} !== 2'b11) begin
            n_fail++;
            $display("FAIL to_sticky: start/err=%b%b required 11", start2, err2);
        end
        @(negedge clk);
        n_cmp++;
        if (err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: err=%b required 0", err2);
        end
    endtask

    initial begin
        blk_a = {PT_A, TW_A, KEY_A};
        blk_b = {PT_B, TW_B, KEY_B};
        core_ct = CT_A;
        done2 = 1'b0;
        ct2_in = '0;
        rst_n = 1'b0;
        lk.in_data = '0;  lk.in_valid = 1'b0;  lk.out_ready = 1'b0;
        lk2.in_data = '0; lk2.in_valid = 1'b0; lk2.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_nominal;
        test_backpressure;
        test_gaps;
        test_reset_mid;
        test_back_to_back;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
